// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared types and counter-width helpers for the FIFO pop controller.
package fifo_pop_pkg;

    typedef enum logic [1:0] {IDLE, BURST, GAP, FLUSH} pop_state_e;

    localparam int unsigned BURST_MAX_DFLT = 8;
    localparam int unsigned GAP_CYC_DFLT   = 2;

    // Down-counters need at least one bit even when the load value is 0.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int unsigned BEAT_W = cnt_w(BURST_MAX_DFLT);
    localparam int unsigned GAP_W  = cnt_w(GAP_CYC_DFLT);

endpackage

// File: rtl/fifo_pop_ctrl_beat_cnt.sv
// Loadable saturating down-counter with zero and last-count flags.
module pop_beat_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Consumer-side FIFO pop controller: watermark-triggered bounded bursts,
// inter-burst gap, and flush-to-empty.
module fifo_pop_ctrl
    import fifo_pop_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAXCOUNT  = 16,
    parameter int LOW_WM    = 4,
    parameter int BURST_MAX = 8,
    parameter int GAP_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    sink_rdy,
    input  logic signed [CNT_W-1:0] fifo_count,
    output logic                    pop,
    output logic                    busy,
    output logic [15:0]             pops_total,
    output logic                    err_ovf
);

    localparam int unsigned W_BEAT = cnt_w(BURST_MAX);
    localparam int unsigned W_GAP  = cnt_w(GAP_CYC);

    pop_state_e  r_state, w_state_nxt;
    logic        r_flush_pend, w_flush_pend_nxt;
    logic [15:0] r_pops_total;
    logic        r_err_ovf;
    logic        w_nonempty, w_empty, w_bad;
    logic        w_beat_load, w_beat_dec, w_beat_zero, w_beat_last;
    logic        w_gap_load, w_gap_dec, w_gap_zero, w_gap_last;

    assign w_nonempty = (fifo_count > 0);
    assign w_empty    = !w_nonempty;
    assign w_bad      = (fifo_count > MAXCOUNT) || (fifo_count < 0);

    assign pop        = ((r_state == BURST) || (r_state == FLUSH)) && sink_rdy && w_nonempty;
    assign busy       = (r_state == BURST) || (r_state == FLUSH);
    assign pops_total = r_pops_total;
    assign err_ovf    = r_err_ovf;

    assign w_beat_dec = pop && (r_state == BURST);
    assign w_gap_dec  = (r_state == GAP);

    pop_beat_cnt #(.W(W_BEAT)) u_beats (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_beat_load),
        .i_load_val (W_BEAT'(BURST_MAX)),
        .i_dec      (w_beat_dec),
        .o_zero     (w_beat_zero),
        .o_last     (w_beat_last)
    );

    pop_beat_cnt #(.W(W_GAP)) u_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_gap_load),
        .i_load_val (W_GAP'(GAP_CYC)),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero),
        .o_last     (w_gap_last)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_load      = 1'b0;
        w_gap_load       = 1'b0;
        // A flush pulse seen while already flushing is absorbed.
        w_flush_pend_nxt = r_flush_pend | (flush && (r_state != FLUSH));
        case (r_state)
            IDLE: begin
                if (r_flush_pend) begin
                    w_state_nxt = FLUSH;
                end else if (enable && (fifo_count >= LOW_WM)) begin
                    w_state_nxt = BURST;
                    w_beat_load = 1'b1;
                end
            end
            BURST: begin
                if (r_flush_pend) begin
                    w_state_nxt = FLUSH;
                end else if ((pop && w_beat_last) || w_beat_zero || w_empty || !enable) begin
                    if (GAP_CYC > 0) begin
                        w_state_nxt = GAP;
                        w_gap_load  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_flush_pend) begin
                    w_state_nxt = FLUSH;
                end else if (w_gap_last || w_gap_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (w_empty) begin
                    w_state_nxt      = IDLE;
                    w_flush_pend_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            r_pops_total <= '0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            if (pop) begin
                r_pops_total <= r_pops_total + 16'd1;
            end
            if (w_bad) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl; the bench plays the occupancy tracker.
module tb_fifo_pop_ctrl;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               flush;
    logic               sink_rdy;
    logic signed [31:0] fifo_count;
    logic               pop;
    logic               busy;
    logic [15:0]        pops_total;
    logic               err_ovf;

    int unsigned n_chk;
    int unsigned n_pass;
    logic [31:0] hist_pop;
    logic [31:0] hist_busy;
    int          cyc;

    fifo_pop_ctrl #(
        .CNT_W     (32),
        .MAXCOUNT  (16),
        .LOW_WM    (4),
        .BURST_MAX (8),
        .GAP_CYC   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flush      (flush),
        .sink_rdy   (sink_rdy),
        .fifo_count (fifo_count),
        .pop        (pop),
        .busy       (busy),
        .pops_total (pops_total),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_hist();
        hist_pop  = '0;
        hist_busy = '0;
        cyc       = 0;
    endtask

    // Sample mid-cycle, then apply the tracker's pop/push update after the edge.
    task automatic tick(input logic push);
        logic p;
        @(negedge clk);
        p = pop;
        if (cyc < 32) begin
            hist_pop[cyc]  = p;
            hist_busy[cyc] = busy;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (p)    fifo_count = fifo_count - 1;
        if (push) fifo_count = fifo_count + 1;
    endtask

    task automatic do_reset(input int cnt);
        rst_n      = 1'b0;
        fifo_count = cnt;
        enable     = 1'b1;
        sink_rdy   = 1'b1;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_hist();
    endtask

    logic [31:0] rdy_vec;
    logic [31:0] push_vec;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr_hist();

        // Reset values hold while rst_n is low, even with a full-enough FIFO.
        rst_n      = 1'b0;
        fifo_count = 10;
        enable     = 1'b1;
        sink_rdy   = 1'b1;
        flush      = 1'b0;
        @(negedge clk);
        chk("t1_rst_pop", 32'(pop), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_total", 32'(pops_total), 32'd0);
        chk("t1_rst_err", 32'(err_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_hist();
        repeat (2) tick(1'b0);
        chk("t1_first_pops", 32'(hist_pop[1:0]), 32'b10);

        // Burst of 8, GAP_CYC gap cycles plus the IDLE decision cycle, then burst of 4.
        do_reset(12);
        repeat (20) tick(1'b0);
        chk("t2_pop_hist", hist_pop[19:0], 32'h0F1FE);
        chk("t2_busy_hist", hist_busy[19:0], 32'h1F1FE);
        chk("t2_total", 32'(pops_total), 32'd12);
        chk("t2_count", fifo_count, 32'd0);

        // Below watermark: nothing; flush then drains exactly 3 words.
        do_reset(3);
        repeat (4) tick(1'b0);
        chk("t3_no_pop", hist_pop[3:0], 32'd0);
        clr_hist();
        flush = 1'b1;
        tick(1'b0);
        flush = 1'b0;
        repeat (7) tick(1'b0);
        chk("t3_pop_hist", hist_pop[7:0], 32'h1C);
        chk("t3_busy_hist", hist_busy[7:0], 32'h3C);
        chk("t3_total", 32'(pops_total), 32'd3);
        chk("t3_count", fifo_count, 32'd0);

        // sink_rdy stalls for two cycles; beat count is kept.
        do_reset(12);
        rdy_vec = 32'hFFFF_FFE7;
        for (int i = 0; i < 12; i++) begin
            sink_rdy = rdy_vec[i];
            tick(1'b0);
        end
        sink_rdy = 1'b1;
        chk("t4_pop_hist", hist_pop[11:0], 32'h7E6);
        chk("t4_busy_hist", hist_busy[11:0], 32'h7FE);
        chk("t4_total", 32'(pops_total), 32'd8);
        chk("t4_count", fifo_count, 32'd4);

        // Drain to 1, then push alongside each pop: occupancy sits at 1 until the burst ends.
        do_reset(4);
        push_vec = 32'h0000_01F0;
        for (int i = 0; i < 12; i++) begin
            tick(push_vec[i]);
        end
        chk("t5_pop_hist", hist_pop[11:0], 32'h1FE);
        chk("t5_count", fifo_count, 32'd1);
        chk("t5_total", 32'(pops_total), 32'd8);

        // Overflow is sticky; reset mid-burst drops pop asynchronously.
        do_reset(10);
        repeat (2) tick(1'b0);
        chk("t6_err_pre", 32'(err_ovf), 32'd0);
        fifo_count = 17;
        tick(1'b0);
        fifo_count = 8;
        chk("t6_err_set", 32'(err_ovf), 32'd1);
        repeat (2) tick(1'b0);
        chk("t6_err_sticky", 32'(err_ovf), 32'd1);
        @(negedge clk);
        chk("t6_pop_pre", 32'(pop), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_pop_rst", 32'(pop), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_err_rst", 32'(err_ovf), 32'd0);
        chk("t6_total_rst", 32'(pops_total), 32'd0);
        @(posedge clk);
        #1;

        // Negative occupancy flags an error and never pops.
        do_reset(0);
        fifo_count = -1;
        repeat (3) tick(1'b0);
        chk("t7_err_neg", 32'(err_ovf), 32'd1);
        chk("t7_no_pop", hist_pop[2:0], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
